lcd_nn_scaler: RTL and testbench

LCD_NN_SCALER -- requirements
Module: lcd_nn_scaler

---
 rtl/lcd_scaler_pkg.sv | 25 ++
 rtl/lcd_line_ram.sv | 34 +++
 rtl/lcd_nn_scaler.sv | 157 +++++++++++++++
 tb/tb_lcd_nn_scaler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_scaler_pkg.sv
// Shared definitions for the nearest-neighbour LCD scaler.
// - Default source/panel geometry.
// - calc_step(): 16.16 fixed-point step used to map panel coordinates to source coordinates.
// - Write-side FSM state encoding.
package lcd_scaler_pkg;

  localparam int unsigned DefSrcW = 400;
  localparam int unsigned DefSrcH = 240;
  localparam int unsigned DefDstW = 800;
  localparam int unsigned DefDstH = 480;

  // Step is src/dst in 16.16 form; upscale only, so it never exceeds 1.0 (17 bits).
  localparam int unsigned StepW = 17;

  function automatic logic [StepW-1:0] calc_step(input int unsigned src, input int unsigned dst);
    return StepW'((src << 16) / dst);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StHold
  } wr_state_e;

endpackage

// File: rtl/lcd_line_ram.sv
// Simple dual-port line RAM holding the two source line banks.
// The bank select is the address MSB, so each bank occupies a power-of-two half of the array.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i     read enable/address; rdata_o is registered and holds while re_i=0
module lcd_line_ram #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_nn_scaler.sv
// Nearest-neighbour upscaler between a streaming RGB565 source and an LCD timing driver.
// One source line is written into the write bank while the driver reads the read bank;
// banks swap at panel line ends where the source row changes. If no complete line is
// waiting, the previous line repeats and underflow pulses.
// Ports:
//   lcd_pclk, rst                   clock, async active-high reset
//   s_valid/s_ready/s_data/s_sof    source pixel stream (s_sof marks pixel (0,0))
//   data_req/pixel_xpos/pixel_ypos  driver pixel request
//   pixel_data                      scaled pixel, valid the cycle after data_req
//   underflow                       one-cycle pulse on a failed line swap
module lcd_nn_scaler
  import lcd_scaler_pkg::*;
#(
  parameter int unsigned SRC_W = DefSrcW,
  parameter int unsigned SRC_H = DefSrcH,
  parameter int unsigned DST_W = DefDstW,
  parameter int unsigned DST_H = DefDstH
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_sof,
  input  logic        data_req,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [15:0] pixel_data,
  output logic        underflow
);

  localparam int unsigned AW = (SRC_W > 1) ? $clog2(SRC_W) : 1;

  localparam logic [StepW-1:0] XStep    = calc_step(SRC_W, DST_W);
  localparam logic [StepW-1:0] YStep    = calc_step(SRC_H, DST_H);
  localparam logic [11:0]      SrcXMax  = 12'(SRC_W - 1);
  localparam logic [AW-1:0]    WrXLast  = AW'(SRC_W - 1);
  localparam logic [10:0]      DstXLast = 11'(DST_W - 1);
  localparam logic [10:0]      DstYLast = 11'(DST_H - 1);

  // 11x17 unsigned product, integer part of the 16.16 result.
  function automatic logic [11:0] scale(input logic [10:0] pos, input logic [StepW-1:0] step);
    logic [27:0] prod;
    prod = 28'(pos) * 28'(step);
    return 12'(prod >> 16);
  endfunction

  wr_state_e     state_q, state_d;
  logic [AW-1:0] wr_x_q, wr_x_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic          rb_valid_q, rb_valid_d;
  logic          underflow_q, underflow_d;
  logic          rd_valid_q;

  logic          accept;
  logic [AW-1:0] eff_x;
  logic [11:0]   sx_full;
  logic [AW-1:0] src_x;
  logic          line_end;
  logic [10:0]   next_y;
  logic          swap_req;
  logic [15:0]   ram_rdata;

  assign s_ready = (state_q == StFill);
  assign accept  = s_valid && s_ready;
  // s_sof resynchronises the line: that pixel always lands at column 0.
  assign eff_x   = s_sof ? '0 : wr_x_q;

  always_comb begin
    sx_full = scale(pixel_xpos, XStep);
    src_x   = (sx_full > SrcXMax) ? SrcXMax[AW-1:0] : sx_full[AW-1:0];
  end

  always_comb begin
    line_end = data_req && (pixel_xpos == DstXLast);
    next_y   = (pixel_ypos == DstYLast) ? '0 : pixel_ypos + 11'd1;
    swap_req = line_end &&
               ((next_y == '0) || (scale(next_y, YStep) != scale(pixel_ypos, YStep)));
  end

  // Swap only ever happens from HOLD, so a line completing in the same cycle as a
  // line-end event is seen as still filling and reported as underflow.
  always_comb begin
    state_d     = state_q;
    wr_x_d      = wr_x_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    rb_valid_d  = rb_valid_q;
    underflow_d = 1'b0;
    case (state_q)
      StIdle: state_d = StFill;
      StFill: begin
        if (accept) begin
          if (eff_x == WrXLast) begin
            wr_x_d  = '0;
            state_d = StHold;
          end else begin
            wr_x_d = eff_x + AW'(1);
          end
        end
      end
      StHold: begin
        if (swap_req) begin
          wb_d       = rb_q;
          rb_d       = wb_q;
          rb_valid_d = 1'b1;
          state_d    = StFill;
        end
      end
      default: state_d = StIdle;
    endcase
    if (swap_req && (state_q != StHold)) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_x_q      <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b1;
      rb_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_x_q      <= wr_x_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      rb_valid_q  <= rb_valid_d;
      underflow_q <= underflow_d;
      if (data_req) begin
        rd_valid_q <= rb_valid_q;
      end
    end
  end

  lcd_line_ram #(
    .AddrW(AW + 1),
    .DataW(16)
  ) u_line_ram (
    .clk_i  (lcd_pclk),
    .we_i   (accept),
    .waddr_i({wb_q, eff_x}),
    .wdata_i(s_data),
    .re_i   (data_req),
    .raddr_i({rb_q, src_x}),
    .rdata_o(ram_rdata)
  );

  // RAM contents are not cleared; the output is masked until a complete line has been swapped in.
  assign pixel_data = rd_valid_q ? ram_rdata : 16'h0000;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_lcd_nn_scaler.sv
module tb_lcd_nn_scaler;

  logic        lcd_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        data_req = 1'b0;
  logic [10:0] pixel_xpos = '0;
  logic [10:0] pixel_ypos = '0;
  logic        s_ready, s_ready_320;
  logic [15:0] pixel_data, pixel_data_320;
  logic        underflow, underflow_320;

  int n_checks = 0;
  int n_fail = 0;
  int uf_cnt;
  logic [15:0] row_main [800];
  logic [15:0] row_320 [800];

  always #5 lcd_pclk = ~lcd_pclk;

  lcd_nn_scaler dut (
    .lcd_pclk  (lcd_pclk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .data_req  (data_req),
    .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos),
    .pixel_data(pixel_data),
    .underflow (underflow)
  );

  lcd_nn_scaler #(
    .SRC_W(320),
    .SRC_H(240),
    .DST_W(800),
    .DST_H(480)
  ) dut320 (
    .lcd_pclk  (lcd_pclk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready_320),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .data_req  (data_req),
    .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos),
    .pixel_data(pixel_data_320),
    .underflow (underflow_320)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one pixel until the main DUT takes it; returns on the falling edge after the accept.
  task automatic send_pixel(input logic [15:0] d, input logic sof);
    int n = 0;
    @(negedge lcd_pclk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    while (!s_ready && n < 4000) begin
      @(negedge lcd_pclk);
      n++;
    end
    if (n >= 4000) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
    end
    @(negedge lcd_pclk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  // Request a full panel row; capture each pixel and count underflow pulses.
  task automatic scan_row(input int y);
    uf_cnt = 0;
    for (int x = 0; x <= 800; x++) begin
      @(negedge lcd_pclk);
      if (x > 0) begin
        row_main[x-1] = pixel_data;
        row_320[x-1]  = pixel_data_320;
      end
      if (underflow) uf_cnt++;
      if (x < 800) begin
        data_req   = 1'b1;
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
      end else begin
        data_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge lcd_pclk);
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_checks++; if (pixel_data !== 16'h0) begin n_fail++; $display("FAIL reset_pixel_data: got %h want 0000", pixel_data); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    n_checks++; if (s_ready_320 !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready_320: got %b want 0", s_ready_320); end
    n_checks++; if (underflow_320 !== 1'b0) begin n_fail++; $display("FAIL reset_underflow_320: got %b want 0", underflow_320); end
    rst = 1'b0;
    @(negedge lcd_pclk);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_fill: s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 400; i++) send_pixel(16'(i), i == 0);
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL ramp_hold: s_ready got %b want 0", s_ready); end
    scan_row(479);
    n_checks++; if (row_main[5] !== 16'h0) begin n_fail++; $display("FAIL preswap_x5: got %h want 0000", row_main[5]); end
    n_checks++; if (row_main[799] !== 16'h0) begin n_fail++; $display("FAIL preswap_x799: got %h want 0000", row_main[799]); end
    n_checks++; if (uf_cnt !== 0) begin n_fail++; $display("FAIL first_swap_uf: got %0d want 0", uf_cnt); end
    scan_row(0);
    n_checks++; if (row_main[0] !== 16'd0) begin n_fail++; $display("FAIL ramp_x0: got %h want 0000", row_main[0]); end
    n_checks++; if (row_main[1] !== 16'd0) begin n_fail++; $display("FAIL ramp_x1: got %h want 0000", row_main[1]); end
    n_checks++; if (row_main[2] !== 16'd1) begin n_fail++; $display("FAIL ramp_x2: got %h want 0001", row_main[2]); end
    n_checks++; if (row_main[3] !== 16'd1) begin n_fail++; $display("FAIL ramp_x3: got %h want 0001", row_main[3]); end
    n_checks++; if (row_main[799] !== 16'd399) begin n_fail++; $display("FAIL ramp_x799: got %0d want 399", row_main[799]); end
    n_checks++; if (row_320[799] !== 16'd319) begin n_fail++; $display("FAIL w320_x799: got %0d want 319", row_320[799]); end
    n_checks++; if (row_320[5] !== 16'd1) begin n_fail++; $display("FAIL w320_x5: got %0d want 1", row_320[5]); end
  endtask

  task automatic test_stall();
    scan_row(1);
    n_checks++; if (uf_cnt !== 1) begin n_fail++; $display("FAIL stall_uf: got %0d pulses want 1", uf_cnt); end
    scan_row(2);
    n_checks++; if (row_main[3] !== 16'd1) begin n_fail++; $display("FAIL stall_repeat_x3: got %h want 0001", row_main[3]); end
    n_checks++; if (row_main[799] !== 16'd399) begin n_fail++; $display("FAIL stall_repeat_x799: got %0d want 399", row_main[799]); end
  endtask

  task automatic test_sof_resync();
    int accepts = 0;
    for (int i = 0; i < 137; i++) send_pixel(16'hDEAD, 1'b0);
    send_pixel(16'hABCD, 1'b1);
    for (int k = 1; k <= 500; k++) begin
      send_pixel(16'h2000 + 16'(k), 1'b0);
      accepts++;
      if (!s_ready) break;
    end
    n_checks++; if (accepts !== 399) begin n_fail++; $display("FAIL sof_accepts: got %0d want 399", accepts); end
    scan_row(3);
    n_checks++; if (uf_cnt !== 0) begin n_fail++; $display("FAIL sof_swap_uf: got %0d want 0", uf_cnt); end
    scan_row(4);
    n_checks++; if (row_main[0] !== 16'hABCD) begin n_fail++; $display("FAIL sof_addr0: got %h want abcd", row_main[0]); end
    n_checks++; if (row_main[2] !== 16'h2001) begin n_fail++; $display("FAIL sof_addr1: got %h want 2001", row_main[2]); end
    n_checks++; if (row_main[799] !== 16'h218F) begin n_fail++; $display("FAIL sof_addr399: got %h want 218f", row_main[799]); end
  endtask

  task automatic test_vertical();
    int uf_total = 0;
    for (int i = 0; i < 400; i++) send_pixel(16'h1000, i == 0);
    fork
      begin
        for (int l = 1; l <= 3; l++)
          for (int i = 0; i < 400; i++) send_pixel(16'h1000 + 16'(l), 1'b0);
      end
      begin
        scan_row(479);
        uf_total = uf_cnt;
        for (int r = 0; r < 6; r++) begin
          logic [15:0] exp_v;
          exp_v = 16'h1000 + 16'(r / 2);
          scan_row(r);
          uf_total += uf_cnt;
          n_checks++;
          if (row_main[0] !== exp_v) begin
            n_fail++; $display("FAIL vert_row%0d_x0: got %h want %h", r, row_main[0], exp_v);
          end
          n_checks++;
          if (row_main[799] !== exp_v) begin
            n_fail++; $display("FAIL vert_row%0d_x799: got %h want %h", r, row_main[799], exp_v);
          end
        end
      end
    join
    n_checks++; if (uf_total !== 0) begin n_fail++; $display("FAIL vert_uf: got %0d want 0", uf_total); end
  endtask

  task automatic test_reset_mid();
    fork
      scan_row(200);
      begin
        repeat (100) @(posedge lcd_pclk);
        #3;
        n_checks++; if (pixel_data !== 16'h1003) begin n_fail++; $display("FAIL pre_rst_data: got %h want 1003", pixel_data); end
        rst = 1'b1;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_s_ready: got %b want 0", s_ready); end
        n_checks++; if (pixel_data !== 16'h0) begin n_fail++; $display("FAIL async_rst_data: got %h want 0000", pixel_data); end
        repeat (3) @(negedge lcd_pclk);
        rst = 1'b0;
      end
    join
    n_checks++; if (row_main[799] !== 16'h0) begin n_fail++; $display("FAIL post_rst_row: got %h want 0000", row_main[799]); end
    for (int i = 0; i < 400; i++) send_pixel(16'h3000, i == 0);
    scan_row(479);
    n_checks++; if (row_main[0] !== 16'h0) begin n_fail++; $display("FAIL fresh_preswap: got %h want 0000", row_main[0]); end
    scan_row(0);
    n_checks++; if (row_main[0] !== 16'h3000) begin n_fail++; $display("FAIL fresh_x0: got %h want 3000", row_main[0]); end
    n_checks++; if (row_main[799] !== 16'h3000) begin n_fail++; $display("FAIL fresh_x799: got %h want 3000", row_main[799]); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_stall();
    test_sof_resync();
    test_vertical();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
